// File: rtl/savior_move_ctrl_pkg.sv
// Shared types and edge/stop bit mapping for the savior movement controller.
package savior_pkg;

    typedef enum logic [2:0] {DIR_NONE, DIR_R, DIR_L, DIR_U, DIR_D} dir_t;
    typedef enum logic [1:0] {IDLE, MOVE, PUSH, BLOCKED} state_t;

    localparam int EDGE_L = 3;
    localparam int EDGE_T = 2;
    localparam int EDGE_R = 1;
    localparam int EDGE_B = 0;

    localparam int FP_MULT_DEFAULT = 64;

    // HitEdgeCode and stopSaviorSignal share one bit layout, indexed by motion direction
    function automatic logic [3:0] edgeMask(input dir_t d);
        logic [3:0] m;
        m = 4'b0000;
        case (d)
            DIR_R:   m[EDGE_R] = 1'b1;
            DIR_L:   m[EDGE_L] = 1'b1;
            DIR_U:   m[EDGE_T] = 1'b1;
            DIR_D:   m[EDGE_B] = 1'b1;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // The key mover reports blocking with its own bit order
    function automatic logic [3:0] stopKeyMask(input dir_t d);
        logic [3:0] m;
        case (d)
            DIR_R:   m = 4'b1000;
            DIR_L:   m = 4'b0010;
            DIR_U:   m = 4'b0001;
            DIR_D:   m = 4'b0100;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/savior_move_ctrl_btn_sync_edge.sv
// Two-flop synchronizer for an active-low button, plus a one-clk press pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic resetN,
    input  logic btnN,
    output logic pressed,
    output logic fallPulse
);

    logic sync_p0, sync_p1, sync_p2;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            sync_p2 <= 1'b1;
        end else begin
            sync_p0 <= btnN;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign pressed   = ~sync_p1;
    assign fallPulse = sync_p2 & ~sync_p1;

endmodule

// File: rtl/savior_move_ctrl.sv
// Savior movement: button sync, per-frame direction select, fixed-point position
// integration and border push-back, feeding the key mover.
import savior_pkg::*;

module savior_move_ctrl #(
    parameter int INIT_X   = 32,
    parameter int INIT_Y   = 400,
    parameter int SPEED    = 128,
    parameter int FP_MULT  = FP_MULT_DEFAULT,
    parameter int PUSHBACK = 64
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               btnRightN,
    input  logic               btnLeftN,
    input  logic               btnUpN,
    input  logic               btnDownN,
    input  logic               btnMagnetN,
    input  logic               collisionSaviorBorder,
    input  logic [3:0]         HitEdgeCode,
    input  logic [3:0]         stopKeySignal,
    input  logic               startLevel2,
    input  logic               startLevel3,
    output logic               moveRightSav,
    output logic               moveLeftSav,
    output logic               moveUpSav,
    output logic [10:0]        XspeedSav,
    output logic [10:0]        YspeedSav,
    output logic               magnetMode,
    output logic [3:0]         stopSaviorSignal,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY
);

    localparam int                 FP_SHIFT  = $clog2(FP_MULT);
    localparam logic signed [31:0] SPEED_FP  = 32'(SPEED);
    localparam logic signed [31:0] PUSH_FP   = 32'(PUSHBACK);
    localparam logic signed [31:0] INIT_X_FP = 32'(INIT_X * FP_MULT);
    localparam logic signed [31:0] INIT_Y_FP = 32'(INIT_Y * FP_MULT);

    function automatic logic signed [10:0] toPixel(input logic signed [31:0] acc);
        logic signed [31:0] px;
        px = acc >>> FP_SHIFT;
        return px[10:0];
    endfunction

    logic rightReq, leftReq, upReq, downReq, magnetPress;

    btn_sync_edge uSyncRight  (.clk(clk), .resetN(resetN), .btnN(btnRightN),  .pressed(rightReq), .fallPulse());
    btn_sync_edge uSyncLeft   (.clk(clk), .resetN(resetN), .btnN(btnLeftN),   .pressed(leftReq),  .fallPulse());
    btn_sync_edge uSyncUp     (.clk(clk), .resetN(resetN), .btnN(btnUpN),     .pressed(upReq),    .fallPulse());
    btn_sync_edge uSyncDown   (.clk(clk), .resetN(resetN), .btnN(btnDownN),   .pressed(downReq),  .fallPulse());
    btn_sync_edge uSyncMagnet (.clk(clk), .resetN(resetN), .btnN(btnMagnetN), .pressed(),         .fallPulse(magnetPress));

    dir_t reqDir;

    always_comb begin
        reqDir = DIR_NONE;
        if (rightReq)     reqDir = DIR_R;
        else if (leftReq) reqDir = DIR_L;
        else if (upReq)   reqDir = DIR_U;
        else if (downReq) reqDir = DIR_D;
    end

    state_t             state, stateNext;
    dir_t               frameDir, frameDirNext, blockDir, blockDirNext;
    logic signed [31:0] posX, posXNext, posY, posYNext;
    logic [3:0]         stopNext;
    logic               doStep, hitForward, levelStart;

    assign levelStart = startLevel2 | startLevel3;
    assign hitForward = collisionSaviorBorder && (|(HitEdgeCode & edgeMask(frameDir)));

    always_comb begin
        stateNext    = state;
        frameDirNext = frameDir;
        blockDirNext = blockDir;
        posXNext     = posX;
        posYNext     = posY;
        stopNext     = stopSaviorSignal;
        doStep       = 1'b0;
        if (levelStart) begin
            stateNext    = IDLE;
            frameDirNext = DIR_NONE;
            blockDirNext = DIR_NONE;
            posXNext     = INIT_X_FP;
            posYNext     = INIT_Y_FP;
            stopNext     = 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (startOfFrame && reqDir != DIR_NONE) begin
                        stateNext = MOVE;
                        doStep    = 1'b1;
                    end
                end
                MOVE: begin
                    // A forward wall hit preempts both the frame step and any key-mover block
                    if (hitForward) begin
                        stateNext    = PUSH;
                        blockDirNext = frameDir;
                    end else if (startOfFrame) begin
                        if (reqDir == DIR_NONE) stateNext = IDLE;
                        else                    doStep    = 1'b1;
                    end
                end
                PUSH: begin
                    if (startOfFrame) begin
                        stateNext = BLOCKED;
                        stopNext  = edgeMask(blockDir);
                        case (blockDir)
                            DIR_R:   posXNext = posX - PUSH_FP;
                            DIR_L:   posXNext = posX + PUSH_FP;
                            DIR_U:   posYNext = posY + PUSH_FP;
                            DIR_D:   posYNext = posY - PUSH_FP;
                            default: posXNext = posX;
                        endcase
                    end
                end
                BLOCKED: begin
                    if (startOfFrame && reqDir != blockDir) begin
                        stopNext = 4'b0000;
                        if (reqDir == DIR_NONE) begin
                            stateNext = IDLE;
                        end else begin
                            stateNext = MOVE;
                            doStep    = 1'b1;
                        end
                    end
                end
                default: stateNext = IDLE;
            endcase
            if (startOfFrame) frameDirNext = reqDir;
            if (doStep && !(|(stopKeySignal & stopKeyMask(reqDir)))) begin
                case (reqDir)
                    DIR_R:   posXNext = posX + SPEED_FP;
                    DIR_L:   posXNext = posX - SPEED_FP;
                    DIR_U:   posYNext = posY - SPEED_FP;
                    DIR_D:   posYNext = posY + SPEED_FP;
                    default: posXNext = posX;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state            <= IDLE;
            frameDir         <= DIR_NONE;
            blockDir         <= DIR_NONE;
            posX             <= INIT_X_FP;
            posY             <= INIT_Y_FP;
            stopSaviorSignal <= 4'b0000;
        end else begin
            state            <= stateNext;
            frameDir         <= frameDirNext;
            blockDir         <= blockDirNext;
            posX             <= posXNext;
            posY             <= posYNext;
            stopSaviorSignal <= stopNext;
        end
    end

    // Magnet state survives level restarts; only the hard reset clears it
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)          magnetMode <= 1'b0;
        else if (magnetPress) magnetMode <= ~magnetMode;
    end

    always_comb begin
        moveRightSav = 1'b1;
        moveLeftSav  = 1'b1;
        moveUpSav    = 1'b1;
        case (frameDir)
            DIR_R: moveRightSav = 1'b0;
            DIR_L: moveLeftSav  = 1'b0;
            DIR_U: moveUpSav    = 1'b0;
            DIR_D: begin
                moveLeftSav = 1'b0;
                moveUpSav   = 1'b0;
            end
            default: moveRightSav = 1'b1;
        endcase
    end

    assign XspeedSav = 11'(SPEED);
    assign YspeedSav = 11'(SPEED);
    assign topLeftX  = toPixel(posX);
    assign topLeftY  = toPixel(posY);

endmodule

// File: tb/tb_savior_move_ctrl.sv
// Directed bench for savior_move_ctrl: movement, priority, borders, key blocking, magnet, restart.
module tb_savior_move_ctrl;

    logic clk = 1'b0;
    logic resetN, startOfFrame;
    logic btnRightN, btnLeftN, btnUpN, btnDownN, btnMagnetN;
    logic collisionSaviorBorder;
    logic [3:0] HitEdgeCode, stopKeySignal;
    logic startLevel2, startLevel3;
    logic moveRightSav, moveLeftSav, moveUpSav, magnetMode;
    logic [10:0] XspeedSav, YspeedSav;
    logic [3:0] stopSaviorSignal;
    logic signed [10:0] topLeftX, topLeftY;

    int passCnt = 0;
    int totalCnt = 0;

    always #5 clk = ~clk;

    savior_move_ctrl dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .btnRightN(btnRightN), .btnLeftN(btnLeftN), .btnUpN(btnUpN), .btnDownN(btnDownN),
        .btnMagnetN(btnMagnetN), .collisionSaviorBorder(collisionSaviorBorder),
        .HitEdgeCode(HitEdgeCode), .stopKeySignal(stopKeySignal),
        .startLevel2(startLevel2), .startLevel3(startLevel3),
        .moveRightSav(moveRightSav), .moveLeftSav(moveLeftSav), .moveUpSav(moveUpSav),
        .XspeedSav(XspeedSav), .YspeedSav(YspeedSav), .magnetMode(magnetMode),
        .stopSaviorSignal(stopSaviorSignal), .topLeftX(topLeftX), .topLeftY(topLeftY)
    );

    task automatic frame();
        repeat (3) @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0; startOfFrame = 1'b0;
        btnRightN = 1'b1; btnLeftN = 1'b1; btnUpN = 1'b1; btnDownN = 1'b1; btnMagnetN = 1'b1;
        collisionSaviorBorder = 1'b0; HitEdgeCode = 4'b0000; stopKeySignal = 4'b0000;
        startLevel2 = 1'b0; startLevel3 = 1'b0;
        repeat (3) @(negedge clk);
        totalCnt++;
        if (topLeftX !== 11'sd32 || topLeftY !== 11'sd400)
            $display("FAIL reset_pos: got X=%0d Y=%0d want X=32 Y=400", topLeftX, topLeftY);
        else passCnt++;
        totalCnt++;
        if ({moveRightSav, moveLeftSav, moveUpSav} !== 3'b111 || stopSaviorSignal !== 4'b0000 || magnetMode !== 1'b0)
            $display("FAIL reset_ctrl: got move=%b stop=%b mag=%b want 111 0000 0",
                     {moveRightSav, moveLeftSav, moveUpSav}, stopSaviorSignal, magnetMode);
        else passCnt++;
        totalCnt++;
        if (XspeedSav !== 11'd128 || YspeedSav !== 11'd128)
            $display("FAIL speed: got %0d/%0d want 128/128", XspeedSav, YspeedSav);
        else passCnt++;
        resetN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_right();
        logic signed [10:0] expX;
        btnRightN = 1'b0;
        for (int f = 1; f <= 3; f++) begin
            frame();
            expX = 11'(32 + 2 * f);
            totalCnt++;
            if (topLeftX !== expX || topLeftY !== 11'sd400 || {moveRightSav, moveLeftSav, moveUpSav} !== 3'b011)
                $display("FAIL right_f%0d: got X=%0d Y=%0d move=%b want X=%0d Y=400 move=011",
                         f, topLeftX, topLeftY, {moveRightSav, moveLeftSav, moveUpSav}, expX);
            else passCnt++;
        end
    endtask

    task automatic test_priority();
        logic signed [10:0] expX;
        btnUpN = 1'b0;
        for (int f = 1; f <= 2; f++) begin
            frame();
            expX = 11'(38 + 2 * f);
            totalCnt++;
            if (topLeftX !== expX || topLeftY !== 11'sd400 || {moveRightSav, moveLeftSav, moveUpSav} !== 3'b011)
                $display("FAIL prio_f%0d: got X=%0d Y=%0d move=%b want X=%0d Y=400 move=011",
                         f, topLeftX, topLeftY, {moveRightSav, moveLeftSav, moveUpSav}, expX);
            else passCnt++;
        end
        btnRightN = 1'b1; btnUpN = 1'b1;
        frame();
        totalCnt++;
        if (topLeftX !== 11'sd42 || {moveRightSav, moveLeftSav, moveUpSav} !== 3'b111)
            $display("FAIL release: got X=%0d move=%b want X=42 move=111",
                     topLeftX, {moveRightSav, moveLeftSav, moveUpSav});
        else passCnt++;
    endtask

    task automatic test_down();
        logic signed [10:0] expY;
        btnDownN = 1'b0;
        for (int f = 1; f <= 2; f++) begin
            frame();
            expY = 11'(400 + 2 * f);
            totalCnt++;
            if (topLeftY !== expY || topLeftX !== 11'sd42 || {moveRightSav, moveLeftSav, moveUpSav} !== 3'b100)
                $display("FAIL down_f%0d: got X=%0d Y=%0d move=%b want X=42 Y=%0d move=100",
                         f, topLeftX, topLeftY, {moveRightSav, moveLeftSav, moveUpSav}, expY);
            else passCnt++;
        end
        btnDownN = 1'b1;
        frame();
    endtask

    task automatic test_left_border();
        btnLeftN = 1'b0;
        repeat (10) frame();
        totalCnt++;
        if (topLeftX !== 11'sd22 || {moveRightSav, moveLeftSav, moveUpSav} !== 3'b101)
            $display("FAIL left_run: got X=%0d move=%b want X=22 move=101",
                     topLeftX, {moveRightSav, moveLeftSav, moveUpSav});
        else passCnt++;
        // Right-edge hit while moving left must be ignored
        collisionSaviorBorder = 1'b1; HitEdgeCode = 4'b0010;
        @(negedge clk);
        collisionSaviorBorder = 1'b0; HitEdgeCode = 4'b0000;
        frame();
        totalCnt++;
        if (topLeftX !== 11'sd20 || stopSaviorSignal !== 4'b0000)
            $display("FAIL side_hit_ignored: got X=%0d stop=%b want X=20 stop=0000", topLeftX, stopSaviorSignal);
        else passCnt++;
        collisionSaviorBorder = 1'b1; HitEdgeCode = 4'b1000;
        @(negedge clk);
        collisionSaviorBorder = 1'b0; HitEdgeCode = 4'b0000;
        frame();
        totalCnt++;
        if (topLeftX !== 11'sd21 || stopSaviorSignal !== 4'b1000)
            $display("FAIL pushback: got X=%0d stop=%b want X=21 stop=1000", topLeftX, stopSaviorSignal);
        else passCnt++;
        frame();
        totalCnt++;
        if (topLeftX !== 11'sd21 || stopSaviorSignal !== 4'b1000)
            $display("FAIL blocked_hold: got X=%0d stop=%b want X=21 stop=1000", topLeftX, stopSaviorSignal);
        else passCnt++;
        btnLeftN = 1'b1; btnUpN = 1'b0;
        frame();
        totalCnt++;
        if (stopSaviorSignal !== 4'b0000 || topLeftY !== 11'sd402 || topLeftX !== 11'sd21 || moveUpSav !== 1'b0)
            $display("FAIL unblock_up: got stop=%b X=%0d Y=%0d up=%b want 0000 X=21 Y=402 up=0",
                     stopSaviorSignal, topLeftX, topLeftY, moveUpSav);
        else passCnt++;
        frame();
        totalCnt++;
        if (topLeftY !== 11'sd400)
            $display("FAIL up_step: got Y=%0d want Y=400", topLeftY);
        else passCnt++;
        btnUpN = 1'b1;
        frame();
    endtask

    task automatic test_stop_key();
        btnRightN = 1'b0; stopKeySignal = 4'b1000;
        frame();
        totalCnt++;
        if (topLeftX !== 11'sd21 || moveRightSav !== 1'b0 || stopSaviorSignal !== 4'b0000)
            $display("FAIL key_block: got X=%0d right=%b stop=%b want X=21 right=0 stop=0000",
                     topLeftX, moveRightSav, stopSaviorSignal);
        else passCnt++;
        stopKeySignal = 4'b0000;
        frame();
        totalCnt++;
        if (topLeftX !== 11'sd23)
            $display("FAIL key_unblock: got X=%0d want X=23", topLeftX);
        else passCnt++;
        stopKeySignal = 4'b0010;
        frame();
        totalCnt++;
        if (topLeftX !== 11'sd25)
            $display("FAIL key_other_bit: got X=%0d want X=25", topLeftX);
        else passCnt++;
        stopKeySignal = 4'b0000; btnRightN = 1'b1;
        frame();
    endtask

    task automatic test_magnet();
        logic expMag;
        expMag = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            expMag = ~expMag;
            btnMagnetN = 1'b0;
            repeat (10) @(negedge clk);
            totalCnt++;
            if (magnetMode !== expMag)
                $display("FAIL magnet_hold_p%0d: got %b want %b", p, magnetMode, expMag);
            else passCnt++;
            btnMagnetN = 1'b1;
            repeat (5) @(negedge clk);
            totalCnt++;
            if (magnetMode !== expMag)
                $display("FAIL magnet_rel_p%0d: got %b want %b", p, magnetMode, expMag);
            else passCnt++;
        end
    endtask

    task automatic test_level_restart();
        btnRightN = 1'b0;
        frame();
        totalCnt++;
        if (topLeftX !== 11'sd27)
            $display("FAIL pre_level: got X=%0d want X=27", topLeftX);
        else passCnt++;
        repeat (3) @(negedge clk);
        startOfFrame = 1'b1; startLevel2 = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0; startLevel2 = 1'b0;
        totalCnt++;
        if (topLeftX !== 11'sd32 || topLeftY !== 11'sd400 || moveRightSav !== 1'b1 || magnetMode !== 1'b1)
            $display("FAIL level2: got X=%0d Y=%0d right=%b mag=%b want X=32 Y=400 right=1 mag=1",
                     topLeftX, topLeftY, moveRightSav, magnetMode);
        else passCnt++;
        frame();
        totalCnt++;
        if (topLeftX !== 11'sd34 || moveRightSav !== 1'b0)
            $display("FAIL after_level: got X=%0d right=%b want X=34 right=0", topLeftX, moveRightSav);
        else passCnt++;
    endtask

    task automatic test_collision_vs_stopkey();
        repeat (3) @(negedge clk);
        startOfFrame = 1'b1; stopKeySignal = 4'b1000; collisionSaviorBorder = 1'b1; HitEdgeCode = 4'b0010;
        @(negedge clk);
        startOfFrame = 1'b0; stopKeySignal = 4'b0000; collisionSaviorBorder = 1'b0; HitEdgeCode = 4'b0000;
        totalCnt++;
        if (topLeftX !== 11'sd34 || stopSaviorSignal !== 4'b0000)
            $display("FAIL coll_key_frame: got X=%0d stop=%b want X=34 stop=0000", topLeftX, stopSaviorSignal);
        else passCnt++;
        frame();
        totalCnt++;
        if (topLeftX !== 11'sd33 || stopSaviorSignal !== 4'b0010)
            $display("FAIL coll_wins: got X=%0d stop=%b want X=33 stop=0010", topLeftX, stopSaviorSignal);
        else passCnt++;
        btnRightN = 1'b1;
        frame();
        totalCnt++;
        if (stopSaviorSignal !== 4'b0000 || moveRightSav !== 1'b1 || topLeftX !== 11'sd33)
            $display("FAIL block_release: got stop=%b right=%b X=%0d want 0000 1 X=33",
                     stopSaviorSignal, moveRightSav, topLeftX);
        else passCnt++;
        startLevel3 = 1'b1;
        @(negedge clk);
        startLevel3 = 1'b0;
        totalCnt++;
        if (topLeftX !== 11'sd32 || topLeftY !== 11'sd400 || magnetMode !== 1'b1)
            $display("FAIL level3: got X=%0d Y=%0d mag=%b want X=32 Y=400 mag=1", topLeftX, topLeftY, magnetMode);
        else passCnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_right();
        test_priority();
        test_down();
        test_left_border();
        test_stop_key();
        test_magnet();
        test_level_restart();
        test_collision_vs_stopkey();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/savior_move_ctrl.md
Name: savior_move_ctrl

Overview:
- Player ("savior") movement stage, directly upstream of the key mover.
- Synchronizes the four active-low direction buttons and the magnet button, then selects one active direction per frame.
- Integrates the savior position in 1/64-pixel fixed point once per frame and handles savior-border collisions.
- Drives the direction, speed, magnet and stopSaviorSignal inputs of the key mover, and obeys its stopKeySignal.

Parameters:
- INIT_X, 32: reset/level-start X pixel.
- INIT_Y, 400: reset/level-start Y pixel.
- SPEED, 128: fixed-point speed magnitude per frame (2 px/frame).
- FP_MULT, 64: fixed-point multiplier; must be a power of 2.
- PUSHBACK, 64: fixed-point pushback applied on a border hit (1 px).

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-clk pulse per frame (30 Hz).
- btnRightN  in  1  raw button, 0 = pressed.
- btnLeftN  in  1  raw button, 0 = pressed.
- btnUpN  in  1  raw button, 0 = pressed.
- btnDownN  in  1  raw button, 0 = pressed.
- btnMagnetN  in  1  raw button, 0 = pressed.
- collisionSaviorBorder  in  1  savior pixels overlap a wall this clk.
- HitEdgeCode  in  4  {Left,Top,Right,Bottom} edge of savior hit.
- stopKeySignal  in  4  from key mover: [3] block right, [1] block left, [0] block up, [2] block down.
- startLevel2  in  1  one-clk level-restart pulse.
- startLevel3  in  1  one-clk level-restart pulse.
- moveRightSav  out  1  0 = right active.
- moveLeftSav  out  1  0 = left active (also 0 for down).
- moveUpSav  out  1  0 = up active (also 0 for down).
- XspeedSav  out  11  constant SPEED.
- YspeedSav  out  11  constant SPEED.
- magnetMode  out  1  toggled magnet state.
- stopSaviorSignal  out  4  [3] savior blocked left, [1] right, [2] up, [0] down.
- topLeftX  out  11 signed  position in pixels.
- topLeftY  out  11 signed  position in pixels.

Behaviour:
- Reset (async, also on startLevel2/3 synchronously):
  - Position = INIT_X*FP_MULT / INIT_Y*FP_MULT.
  - stopSaviorSignal = 0; all move* outputs = 1; state = IDLE.
  - magnetMode = 0 on resetN only; unchanged by level pulses.
- Synchronizer: 2-flop sync on all five buttons. Direction request is sampled only on startOfFrame.
- Direction select, fixed priority R > L > U > D:
  - Exactly one direction is active.
  - Encoding: right -> moveRightSav=0. Left -> moveLeftSav=0. Up -> moveUpSav=0. Down -> moveLeftSav=0 and moveUpSav=0. None -> all 1.
  - move* outputs update one clk after the startOfFrame sample and hold for the frame.
- Magnet: a synchronized falling edge of btnMagnetN toggles magnetMode; one toggle per press, no auto-repeat.
- FSM:
  - IDLE: no request. Go to MOVE when a request is sampled.
  - MOVE: on startOfFrame, pos += ±SPEED on the active axis, unless the matching stopKeySignal bit is set (then hold).
    - On collisionSaviorBorder with the HitEdgeCode bit in the direction of motion: go to PUSH.
    - Request released: go to IDLE.
  - PUSH: at the next startOfFrame, move PUSHBACK opposite to the blocked direction. Set the matching stopSaviorSignal bit. Go to BLOCKED.
  - BLOCKED: position held while the request stays in the blocked direction.
    - Request changes to another direction: clear the bit, go to MOVE.
    - Request released: clear the bit, go to IDLE.
- Collisions on edges not in the direction of motion are ignored.
- A level pulse coincident with startOfFrame: the level pulse wins.
- A border collision and a stopKeySignal bit in the same frame: the border collision wins (PUSH).
- Arithmetic: 32-bit signed accumulators. topLeftX/Y = accumulator / FP_MULT (arithmetic shift), truncated to 11 bits.

Decomposition:
- Package savior_pkg:
  - dir_t enum {DIR_NONE, DIR_R, DIR_L, DIR_U, DIR_D}.
  - state_t enum {IDLE, MOVE, PUSH, BLOCKED}.
  - Edge index constants EDGE_L=3, EDGE_T=2, EDGE_R=1, EDGE_B=0.
  - FP_MULT default.
- Sub-module btn_sync_edge: 2-flop synchronizer plus falling-edge pulse, instantiated 5×.

Test Plan:
- Reset, then btnRightN=0 for 3 frames -> moveRightSav=0; topLeftX 32→34→36→38; topLeftY=400.
- btnRightN=0 and btnUpN=0 together -> right wins; moveUpSav=1; only X changes.
- btnDownN=0 -> moveLeftSav=0 and moveUpSav=0; topLeftY +2/frame.
- Moving left, collisionSaviorBorder=1, HitEdgeCode=4'b1000 at X=20 -> next frame X=21, stopSaviorSignal=4'b1000, X held while left is held. Press up -> bit clears, Y decreases.
- Moving right with stopKeySignal[3]=1 -> X held; stopSaviorSignal stays 0.
- Two btnMagnetN presses -> magnetMode 0→1→0. startLevel2 mid-move -> X=32, Y=400; magnetMode unchanged.
